// File: rtl/sram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared definitions for the asynchronous SRAM controller. It holds the FSM
// state encoding, the default timing constants and the helper that sizes the
// phase counter. The controller, the request interface and any bench that
// needs the defaults all import this package.
// ---------------------------------------------------------------------------
package sram_ctrl_pkg;

  // FSM state encodings (3-bit).
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_SETUP = 3'd1,
    ST_WR_PULSE = 3'd2,
    ST_WR_HOLD  = 3'd3,
    ST_RD_WAIT  = 3'd4,
    ST_TURN     = 3'd5
  } state_e;

  // Default geometry and timing, in clk cycles.
  localparam int DEF_AW         = 18;
  localparam int DEF_DW         = 16;
  localparam int DEF_WR_SETUP   = 1;
  localparam int DEF_WR_PULSE   = 2;
  localparam int DEF_RD_WAIT    = 2;
  localparam int DEF_TURNAROUND = 1;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Width of the phase counter. It must hold the longest phase length.
  function automatic int cnt_width(input int ws, input int wp, input int rw, input int ta);
    return $clog2(max4(ws, wp, rw, ta) + 1);
  endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// ---------------------------------------------------------------------------
// sram_ctrl_if
// Request/response port of the SRAM controller.
//   req_valid/req_ready : handshake. Transfer on an edge where both are high.
//   req_we              : 1 = write, 0 = read.
//   req_addr            : word address (AW bits).
//   req_wdata           : write data (DW bits).
//   req_be              : active-high byte enables (DW/8 bits), writes only.
//   rsp_valid           : one-cycle pulse per completed operation.
//   rsp_rdata           : read data. Holds its value between reads.
// modport master : the requester side. modport slave : the controller side.
// ---------------------------------------------------------------------------
interface sram_ctrl_if
  import sram_ctrl_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [AW-1:0]     req_addr;
  logic [DW-1:0]     req_wdata;
  logic [DW/8-1:0]   req_be;
  logic              rsp_valid;
  logic [DW-1:0]     rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/sram_ctrl_timer.sv
// ---------------------------------------------------------------------------
// sram_ctrl_timer
// Loadable down-counter that times each FSM phase. Loading N makes done rise
// N-1 cycles later, so a state that leaves on done lasts exactly N cycles.
// The count stops at 0.
//   clk, rst  : clock, asynchronous active-high reset.
//   load      : load load_val this cycle (takes priority over counting).
//   load_val  : phase length in cycles.
//   done      : count == 1.
// ---------------------------------------------------------------------------
module sram_ctrl_timer #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // NOTE: assign a default at the top of every always_comb so that no path
  // leaves the signal unassigned, which would infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done = (cnt_q == CW'(1));

endmodule

// File: rtl/sram_ctrl.sv
// ---------------------------------------------------------------------------
// sram_ctrl
// Controller for an external asynchronous SRAM with active-low CS/OE/WE and
// per-byte lane enables. It takes one request at a time over a valid/ready
// port and sequences the strobes with programmable setup, pulse, wait and
// turnaround phases. The tristate pads live outside this block. Here we only
// produce the data-out value and its drive enable.
//   clk, rst            : clock, asynchronous active-high reset.
//   bus (slave)         : request/response port (see sram_ctrl_if).
//   sram_addr           : SRAM address. Holds its value while idle.
//   sram_cs_n/oe_n/we_n : active-low strobes.
//   sram_be_n           : active-low byte lane enables.
//   sram_d_o, sram_d_oe : data to pads and pad drive enable.
//   sram_d_i            : data from pads.
// Every sram_* output comes straight from a flop. The output decode looks at
// the next state, so each strobe changes on the same edge as the state.
// ---------------------------------------------------------------------------
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int WR_SETUP   = DEF_WR_SETUP,
  parameter int WR_PULSE   = DEF_WR_PULSE,
  parameter int RD_WAIT    = DEF_RD_WAIT,
  parameter int TURNAROUND = DEF_TURNAROUND
) (
  input  logic            clk,
  input  logic            rst,
  sram_ctrl_if.slave      bus,
  output logic [AW-1:0]   sram_addr,
  output logic            sram_cs_n,
  output logic            sram_oe_n,
  output logic            sram_we_n,
  output logic [DW/8-1:0] sram_be_n,
  output logic [DW-1:0]   sram_d_o,
  output logic            sram_d_oe,
  input  logic [DW-1:0]   sram_d_i
);

  localparam int NB = DW / 8;
  localparam int CW = cnt_width(WR_SETUP, WR_PULSE, RD_WAIT, TURNAROUND);

  state_e state_q, state_d;

  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [AW-1:0] sram_addr_q, sram_addr_d;
  logic [DW-1:0] sram_d_o_q,  sram_d_o_d;
  logic [NB-1:0] sram_be_n_q, sram_be_n_d;
  logic          sram_cs_n_q, sram_cs_n_d;
  logic          sram_oe_n_q, sram_oe_n_d;
  logic          sram_we_n_q, sram_we_n_d;
  logic          sram_d_oe_q, sram_d_oe_d;

  logic          accept;
  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_done;

  // Ready is a registered copy of "next state is IDLE". It is low in
  // every busy state, so this qualifies the accept on its own.
  assign accept = bus.req_valid && req_ready_q;

  sram_ctrl_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Next-state logic. The timer is loaded with a phase length on the
  // transition into each timed state.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          tmr_load = 1'b1;
          if (bus.req_we) begin
            state_d = ST_WR_SETUP;
            tmr_val = CW'(WR_SETUP);
          end else begin
            state_d = ST_RD_WAIT;
            tmr_val = CW'(RD_WAIT);
          end
        end
      end
      ST_WR_SETUP: begin
        if (tmr_done) begin
          state_d  = ST_WR_PULSE;
          tmr_load = 1'b1;
          tmr_val  = CW'(WR_PULSE);
        end
      end
      ST_WR_PULSE: begin
        if (tmr_done) state_d = ST_WR_HOLD;
      end
      ST_WR_HOLD: begin
        state_d = ST_IDLE;
      end
      ST_RD_WAIT: begin
        if (tmr_done) begin
          state_d  = ST_TURN;
          tmr_load = 1'b1;
          tmr_val  = CW'(TURNAROUND);
        end
      end
      ST_TURN: begin
        if (tmr_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state, so every output is registered.
  always_comb begin
    sram_cs_n_d = 1'b1;
    sram_oe_n_d = 1'b1;
    sram_we_n_d = 1'b1;
    sram_d_oe_d = 1'b0;
    sram_be_n_d = '1;
    sram_addr_d = sram_addr_q;
    sram_d_o_d  = sram_d_o_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    req_ready_d = (state_d == ST_IDLE);

    case (state_d)
      ST_WR_SETUP, ST_WR_HOLD: begin
        sram_cs_n_d = 1'b0;
        sram_d_oe_d = 1'b1;
        sram_be_n_d = sram_be_n_q;
      end
      ST_WR_PULSE: begin
        sram_cs_n_d = 1'b0;
        sram_we_n_d = 1'b0;
        sram_d_oe_d = 1'b1;
        sram_be_n_d = sram_be_n_q;
      end
      ST_RD_WAIT: begin
        sram_cs_n_d = 1'b0;
        sram_oe_n_d = 1'b0;
        sram_be_n_d = '0;
      end
      default: ;
    endcase

    // Request fields are captured at the accept edge. The write lanes are
    // then held through the write phases above.
    if (accept) begin
      sram_addr_d = bus.req_addr;
      if (bus.req_we) begin
        sram_d_o_d  = bus.req_wdata;
        sram_be_n_d = ~bus.req_be;
      end
    end

    if (state_q == ST_RD_WAIT && state_d == ST_TURN) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = sram_d_i;
    end
    if (state_q == ST_WR_HOLD) begin
      rsp_valid_d = 1'b1;
    end
  end

  // State and output registers. The async reset pulls the strobes and the
  // pad enable inactive at once and drops any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      sram_addr_q <= '0;
      sram_d_o_q  <= '0;
      sram_be_n_q <= '1;
      sram_cs_n_q <= 1'b1;
      sram_oe_n_q <= 1'b1;
      sram_we_n_q <= 1'b1;
      sram_d_oe_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      sram_addr_q <= sram_addr_d;
      sram_d_o_q  <= sram_d_o_d;
      sram_be_n_q <= sram_be_n_d;
      sram_cs_n_q <= sram_cs_n_d;
      sram_oe_n_q <= sram_oe_n_d;
      sram_we_n_q <= sram_we_n_d;
      sram_d_oe_q <= sram_d_oe_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign sram_addr     = sram_addr_q;
  assign sram_d_o      = sram_d_o_q;
  assign sram_be_n     = sram_be_n_q;
  assign sram_cs_n     = sram_cs_n_q;
  assign sram_oe_n     = sram_oe_n_q;
  assign sram_we_n     = sram_we_n_q;
  assign sram_d_oe     = sram_d_oe_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_ctrl
// Directed bench for sram_ctrl. dut_a uses the default timing and is attached
// to a behavioural SRAM model with a 15 ns read access time. dut_b uses the
// swept timing (3/1/4/2) and is attached to a combinational read pattern.
// Both DUTs see the same request stream. The "sel" input picks which one the
// measurement task observes.
// Sample index j counts negedges after the accept edge E0, so sample j shows
// the register values after edge E0+j.
// ---------------------------------------------------------------------------
module tb_sram_ctrl;
  import sram_ctrl_pkg::*;

  localparam int AW = 18;
  localparam int DW = 16;
  localparam int NB = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Shared request drive.
  logic          req_valid = 1'b0;
  logic          req_we    = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [NB-1:0] req_be    = '0;

  sram_ctrl_if #(.AW(AW), .DW(DW)) bus_a ();
  sram_ctrl_if #(.AW(AW), .DW(DW)) bus_b ();

  assign bus_a.req_valid = req_valid;
  assign bus_a.req_we    = req_we;
  assign bus_a.req_addr  = req_addr;
  assign bus_a.req_wdata = req_wdata;
  assign bus_a.req_be    = req_be;
  assign bus_b.req_valid = req_valid;
  assign bus_b.req_we    = req_we;
  assign bus_b.req_addr  = req_addr;
  assign bus_b.req_wdata = req_wdata;
  assign bus_b.req_be    = req_be;

  logic [AW-1:0] a_addr, b_addr;
  logic          a_cs_n, a_oe_n, a_we_n, a_d_oe;
  logic          b_cs_n, b_oe_n, b_we_n, b_d_oe;
  logic [NB-1:0] a_be_n, b_be_n;
  logic [DW-1:0] a_d_o, a_d_i, b_d_o, b_d_i;

  sram_ctrl #(.AW(AW), .DW(DW), .WR_SETUP(1), .WR_PULSE(2), .RD_WAIT(2), .TURNAROUND(1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a),
    .sram_addr(a_addr), .sram_cs_n(a_cs_n), .sram_oe_n(a_oe_n), .sram_we_n(a_we_n),
    .sram_be_n(a_be_n), .sram_d_o(a_d_o), .sram_d_oe(a_d_oe), .sram_d_i(a_d_i)
  );

  sram_ctrl #(.AW(AW), .DW(DW), .WR_SETUP(3), .WR_PULSE(1), .RD_WAIT(4), .TURNAROUND(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b),
    .sram_addr(b_addr), .sram_cs_n(b_cs_n), .sram_oe_n(b_oe_n), .sram_we_n(b_we_n),
    .sram_be_n(b_be_n), .sram_d_o(b_d_o), .sram_d_oe(b_d_oe), .sram_d_i(b_d_i)
  );

  // SRAM model for dut_a. Writes commit on the rising edge of WE.
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] a_d_i_r = 'x;
  assign a_d_i = a_d_i_r;

  always @(posedge a_we_n) begin
    logic [DW-1:0] w;
    if (!a_cs_n && !rst) begin
      w = mem.exists(a_addr) ? mem[a_addr] : '0;
      if (!a_be_n[0]) w[7:0]  = a_d_o[7:0];
      if (!a_be_n[1]) w[15:8] = a_d_o[15:8];
      mem[a_addr] = w;
    end
  end

  always @(negedge a_oe_n) begin
    a_d_i_r = 'x;
    #15;
    if (mem.exists(a_addr)) a_d_i_r = mem[a_addr];
    else                    a_d_i_r = '0;
  end

  // Read pattern for dut_b.
  assign b_d_i = b_oe_n ? '0 : (16'h5A5A ^ b_addr[15:0]);

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return '0;
  endfunction

  // Observation mux.
  bit            sel = 1'b0;
  logic          o_cs_n, o_oe_n, o_we_n, o_d_oe, o_ready, o_rsp_valid;
  logic [NB-1:0] o_be_n;
  logic [DW-1:0] o_rdata;
  assign o_cs_n      = sel ? b_cs_n : a_cs_n;
  assign o_oe_n      = sel ? b_oe_n : a_oe_n;
  assign o_we_n      = sel ? b_we_n : a_we_n;
  assign o_d_oe      = sel ? b_d_oe : a_d_oe;
  assign o_be_n      = sel ? b_be_n : a_be_n;
  assign o_ready     = sel ? bus_b.req_ready : bus_a.req_ready;
  assign o_rsp_valid = sel ? bus_b.rsp_valid : bus_a.rsp_valid;
  assign o_rdata     = sel ? bus_b.rsp_rdata : bus_a.rsp_rdata;

  typedef struct {
    bit            accepted;
    int            we_first;
    int            we_cnt;
    int            cs_cnt;
    int            oe_cnt;
    int            doe_cnt;
    int            rsp_cnt;
    int            rsp_first;
    int            rdy_first;
    logic [DW-1:0] rdata;
    logic [NB-1:0] be_n0;
  } stats_t;

  // Issues one request and gathers n samples of the selected DUT.
  task automatic run_op(input bit s, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input logic [NB-1:0] be,
                        input int n, output stats_t st);
    st.accepted = 1'b0; st.we_first = -1; st.we_cnt = 0; st.cs_cnt = 0;
    st.oe_cnt = 0; st.doe_cnt = 0; st.rsp_cnt = 0; st.rsp_first = -1;
    st.rdy_first = -1; st.rdata = '0; st.be_n0 = '0;
    sel = s;
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = data; req_be = be; req_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      if (o_ready) begin
        st.accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!st.accepted) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready never high, required high within 50 cycles");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      if (j == 0) begin
        req_valid = 1'b0;
        st.be_n0  = o_be_n;
      end
      if (!o_we_n) begin
        st.we_cnt++;
        if (st.we_first < 0) st.we_first = j;
      end
      if (!o_cs_n) st.cs_cnt++;
      if (!o_oe_n) st.oe_cnt++;
      if (o_d_oe)  st.doe_cnt++;
      if (o_rsp_valid) begin
        st.rsp_cnt++;
        if (st.rsp_first < 0) begin
          st.rsp_first = j;
          st.rdata     = o_rdata;
        end
      end
      if (o_ready && st.rdy_first < 0) st.rdy_first = j;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if ({a_cs_n, a_oe_n, a_we_n} !== 3'b111) begin errors++; $display("FAIL rst_strobes: got %b required 111", {a_cs_n, a_oe_n, a_we_n}); end
    checks++; if (a_be_n !== 2'b11) begin errors++; $display("FAIL rst_be_n: got %b required 11", a_be_n); end
    checks++; if (a_d_oe !== 1'b0) begin errors++; $display("FAIL rst_d_oe: got %b required 0", a_d_oe); end
    checks++; if ({a_addr, a_d_o} !== '0) begin errors++; $display("FAIL rst_addr_data: got %h/%h required 0/0", a_addr, a_d_o); end
    checks++; if (bus_a.rsp_rdata !== 16'h0) begin errors++; $display("FAIL rst_rdata: got %h required 0000", bus_a.rsp_rdata); end
    checks++; if ({bus_a.rsp_valid, bus_a.req_ready} !== 2'b00) begin errors++; $display("FAIL rst_valid_ready: got %b required 00", {bus_a.rsp_valid, bus_a.req_ready}); end
    rst = 1'b0;
    #1;
    checks++; if (bus_a.req_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %b required 0", bus_a.req_ready); end
    @(negedge clk);
    checks++; if (bus_a.req_ready !== 1'b1) begin errors++; $display("FAIL ready_first_edge: got %b required 1", bus_a.req_ready); end
  endtask

  task automatic test_write();
    stats_t st;
    run_op(1'b0, 1'b1, 18'h0575D, 16'hDEAD, 2'b11, 8, st);
    if (!st.accepted) return;
    checks++; if (st.we_first !== 1) begin errors++; $display("FAIL wr_we_start: got j=%0d required j=1", st.we_first); end
    checks++; if (st.we_cnt !== 2) begin errors++; $display("FAIL wr_we_width: got %0d required 2", st.we_cnt); end
    checks++; if (st.cs_cnt !== 4) begin errors++; $display("FAIL wr_cs_width: got %0d required 4", st.cs_cnt); end
    checks++; if (st.doe_cnt !== 4) begin errors++; $display("FAIL wr_doe_width: got %0d required 4", st.doe_cnt); end
    checks++; if (st.oe_cnt !== 0) begin errors++; $display("FAIL wr_oe_low: got %0d required 0", st.oe_cnt); end
    checks++; if (st.rsp_cnt !== 1 || st.rsp_first !== 4) begin errors++; $display("FAIL wr_rsp: got %0d pulses at j=%0d required 1 at j=4", st.rsp_cnt, st.rsp_first); end
    checks++; if (st.rdy_first !== 4) begin errors++; $display("FAIL wr_ready: got j=%0d required j=4", st.rdy_first); end
    checks++; if (mem_rd(18'h0575D) !== 16'hDEAD) begin errors++; $display("FAIL wr_mem: got %h required DEAD", mem_rd(18'h0575D)); end
  endtask

  task automatic test_read();
    stats_t st;
    run_op(1'b0, 1'b0, 18'h0575D, 16'h0000, 2'b00, 8, st);
    if (!st.accepted) return;
    checks++; if (st.oe_cnt !== 2 || st.cs_cnt !== 2) begin errors++; $display("FAIL rd_oe_cs: got oe=%0d cs=%0d required 2/2", st.oe_cnt, st.cs_cnt); end
    checks++; if (st.doe_cnt !== 0) begin errors++; $display("FAIL rd_doe: got %0d required 0", st.doe_cnt); end
    checks++; if (st.rsp_cnt !== 1 || st.rsp_first !== 2) begin errors++; $display("FAIL rd_rsp: got %0d pulses at j=%0d required 1 at j=2", st.rsp_cnt, st.rsp_first); end
    checks++; if (st.rdata !== 16'hDEAD) begin errors++; $display("FAIL rd_data: got %h required DEAD", st.rdata); end
    checks++; if (st.rdy_first !== 3) begin errors++; $display("FAIL rd_ready: got j=%0d required j=3", st.rdy_first); end
    checks++; if (bus_a.rsp_rdata !== 16'hDEAD) begin errors++; $display("FAIL rd_hold: got %h required DEAD", bus_a.rsp_rdata); end
  endtask

  task automatic test_partial_write();
    stats_t st;
    run_op(1'b0, 1'b1, 18'h3AB34, 16'hBEEF, 2'b01, 8, st);
    if (!st.accepted) return;
    checks++; if (st.be_n0 !== 2'b10) begin errors++; $display("FAIL pw_be_n: got %b required 10", st.be_n0); end
    checks++; if (mem_rd(18'h3AB34) !== 16'h00EF) begin errors++; $display("FAIL pw_mem: got %h required 00EF", mem_rd(18'h3AB34)); end
    run_op(1'b0, 1'b0, 18'h3AB34, 16'h0000, 2'b00, 8, st);
    if (!st.accepted) return;
    checks++; if (st.rdata !== 16'h00EF) begin errors++; $display("FAIL pw_read: got %h required 00EF", st.rdata); end
  endtask

  task automatic test_zero_be();
    stats_t st;
    run_op(1'b0, 1'b1, 18'h0575D, 16'hFFFF, 2'b00, 8, st);
    if (!st.accepted) return;
    checks++; if (st.be_n0 !== 2'b11) begin errors++; $display("FAIL zbe_be_n: got %b required 11", st.be_n0); end
    checks++; if (st.cs_cnt !== 4 || st.we_cnt !== 2) begin errors++; $display("FAIL zbe_cycle: got cs=%0d we=%0d required 4/2", st.cs_cnt, st.we_cnt); end
    checks++; if (st.rsp_cnt !== 1 || st.rsp_first !== 4) begin errors++; $display("FAIL zbe_rsp: got %0d pulses at j=%0d required 1 at j=4", st.rsp_cnt, st.rsp_first); end
    checks++; if (mem_rd(18'h0575D) !== 16'hDEAD) begin errors++; $display("FAIL zbe_mem: got %h required DEAD", mem_rd(18'h0575D)); end
  endtask

  // Read of 0x3AB34 with req_valid held high, then a write to 0x00100.
  task automatic test_back_to_back();
    bit            ok = 1'b0;
    bit            oe_seen_low = 1'b0;
    int            oe_rise = -1, doe_first = -1, rdy_early = 0, rsp_cnt = 0, overlap = 0;
    logic          rdy_j3 = 1'b0;
    logic [DW-1:0] rd_val = '0;
    sel = 1'b0;
    @(negedge clk);
    req_we = 1'b0; req_addr = 18'h3AB34; req_be = 2'b00; req_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      if (o_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL b2b_accept_timeout: req_ready never high, required high within 50 cycles");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (j == 0) begin
        req_we = 1'b1; req_addr = 18'h00100; req_wdata = 16'h1234; req_be = 2'b11;
      end
      if (!o_oe_n) oe_seen_low = 1'b1;
      if (o_oe_n && oe_seen_low && oe_rise < 0) oe_rise = j;
      if (o_d_oe && doe_first < 0) begin
        doe_first = j;
        req_valid = 1'b0;
      end
      if (o_d_oe && !o_oe_n) overlap++;
      if (j < 3 && o_ready) rdy_early++;
      if (j == 3) rdy_j3 = o_ready;
      if (o_rsp_valid) begin
        rsp_cnt++;
        if (rsp_cnt == 1) rd_val = o_rdata;
      end
    end
    req_valid = 1'b0;
    checks++; if (oe_rise !== 2) begin errors++; $display("FAIL b2b_oe_rise: got j=%0d required j=2", oe_rise); end
    checks++; if (doe_first !== 4) begin errors++; $display("FAIL b2b_doe_rise: got j=%0d required j=4", doe_first); end
    checks++; if (overlap !== 0) begin errors++; $display("FAIL b2b_overlap: got %0d cycles required 0", overlap); end
    checks++; if (rdy_early !== 0 || rdy_j3 !== 1'b1) begin errors++; $display("FAIL b2b_ready: got early=%0d j3=%b required 0/1", rdy_early, rdy_j3); end
    checks++; if (rsp_cnt !== 2) begin errors++; $display("FAIL b2b_rsp_count: got %0d required 2", rsp_cnt); end
    checks++; if (rd_val !== 16'h00EF) begin errors++; $display("FAIL b2b_read: got %h required 00EF", rd_val); end
    checks++; if (mem_rd(18'h00100) !== 16'h1234) begin errors++; $display("FAIL b2b_write: got %h required 1234", mem_rd(18'h00100)); end
  endtask

  task automatic test_reset_mid_op();
    stats_t st;
    int rsp_cnt = 0, rdy_first = -1;
    run_op(1'b0, 1'b1, 18'h00200, 16'h5555, 2'b11, 2, st);
    if (!st.accepted) return;
    checks++; if (st.we_cnt !== 1) begin errors++; $display("FAIL rmo_in_pulse: got we low %0d required 1", st.we_cnt); end
    rst = 1'b1;
    #1;
    checks++; if ({a_we_n, a_cs_n} !== 2'b11) begin errors++; $display("FAIL rmo_strobes: got %b required 11", {a_we_n, a_cs_n}); end
    checks++; if (a_d_oe !== 1'b0) begin errors++; $display("FAIL rmo_d_oe: got %b required 0", a_d_oe); end
    checks++; if ({bus_a.rsp_valid, bus_a.req_ready} !== 2'b00) begin errors++; $display("FAIL rmo_valid_ready: got %b required 00", {bus_a.rsp_valid, bus_a.req_ready}); end
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (bus_a.rsp_valid) rsp_cnt++;
      if (bus_a.req_ready && rdy_first < 0) rdy_first = j;
    end
    checks++; if (rsp_cnt !== 0) begin errors++; $display("FAIL rmo_no_rsp: got %0d pulses required 0", rsp_cnt); end
    checks++; if (rdy_first !== 0) begin errors++; $display("FAIL rmo_ready: got j=%0d required j=0", rdy_first); end
    checks++; if (mem.exists(18'h00200) !== 0) begin errors++; $display("FAIL rmo_mem: got entry %h required none", mem_rd(18'h00200)); end
  endtask

  task automatic test_param_sweep();
    stats_t st;
    run_op(1'b1, 1'b1, 18'h00F0F, 16'hA5A5, 2'b11, 10, st);
    if (!st.accepted) return;
    checks++; if (st.we_first !== 3 || st.we_cnt !== 1) begin errors++; $display("FAIL sw_we: got j=%0d width %0d required j=3 width 1", st.we_first, st.we_cnt); end
    checks++; if (st.cs_cnt !== 5) begin errors++; $display("FAIL sw_cs: got %0d required 5", st.cs_cnt); end
    checks++; if (st.rsp_first !== 5 || st.rdy_first !== 5) begin errors++; $display("FAIL sw_wr_done: got rsp j=%0d ready j=%0d required 5/5", st.rsp_first, st.rdy_first); end
    run_op(1'b1, 1'b0, 18'h00F0F, 16'h0000, 2'b00, 10, st);
    if (!st.accepted) return;
    checks++; if (st.oe_cnt !== 4 || st.doe_cnt !== 0) begin errors++; $display("FAIL sw_rd_strobes: got oe=%0d doe=%0d required 4/0", st.oe_cnt, st.doe_cnt); end
    checks++; if (st.rsp_cnt !== 1 || st.rsp_first !== 4) begin errors++; $display("FAIL sw_rd_rsp: got %0d pulses at j=%0d required 1 at j=4", st.rsp_cnt, st.rsp_first); end
    checks++; if (st.rdata !== 16'h5555) begin errors++; $display("FAIL sw_rd_data: got %h required 5555", st.rdata); end
    checks++; if (st.rdy_first !== 6) begin errors++; $display("FAIL sw_rd_ready: got j=%0d required j=6", st.rdy_first); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish within 300 us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_partial_write();
    test_zero_be();
    test_back_to_back();
    test_reset_mid_op();
    test_param_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
